// File: rtl/sort8_stream.sv
// Streaming 8-element insertion sorter: fill 8 values, then drain them in sorted order.
// Define SORT8_STREAM_ASCENDING_EN for non-decreasing output (default is non-increasing).
module sort8_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on valid, and valid/data hold until taken.
    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_count;
    logic [WIDTH-1:0] r_slot [8];
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_last;

    logic             w_take_in;
    logic             w_take_out;
    logic [7:0]       w_before;
    logic [3:0]       w_k;
    logic [WIDTH-1:0] w_ins   [8];
    logic [WIDTH-1:0] w_shift [8];

    assign w_take_in  = in_valid && r_in_ready;
    assign w_take_out = r_out_valid && out_ready;

    // A stored slot stays ahead of the new value when it wins (or ties) the compare.
    always_comb begin
        w_before = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef SORT8_STREAM_ASCENDING_EN
            w_before[i] = (4'(i) < r_count) && (r_slot[i] <= in_data);
`else
            w_before[i] = (4'(i) < r_count) && (r_slot[i] >= in_data);
`endif
        end
    end

    always_comb begin
        w_k = '0;
        for (int i = 0; i < 8; i++) begin
            w_k = w_k + 4'(w_before[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_ins[i] = r_slot[i];
        end
        if (w_k == 4'd0) begin
            w_ins[0] = in_data;
        end
        for (int i = 1; i < 8; i++) begin
            if (4'(i) == w_k) begin
                w_ins[i] = in_data;
            end else if (4'(i) > w_k) begin
                w_ins[i] = r_slot[i-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            w_shift[i] = r_slot[i+1];
        end
        w_shift[7] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_take_in) begin
                        r_slot  <= w_ins;
                        r_count <= r_count + 4'd1;
                        if (r_count == 4'd7) begin
                            r_state     <= ST_DRAIN;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_take_out) begin
                        r_slot  <= w_shift;
                        r_count <= r_count - 4'd1;
                        if (r_count == 4'd1) begin
                            r_state     <= ST_FILL;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            // Flag the final element as soon as it reaches slot 0.
                            r_out_last <= (r_count == 4'd2);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_FILL;
                    r_count     <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign out_data    = r_out_valid ? r_slot[0] : '0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sort8_stream.sv
// Randomized scoreboard bench for sort8_stream: driver tasks feed batches, a
// sorted reference model fills exp_q, and a negedge monitor checks every output.
module tb_sort8_stream;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic         dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_v;
    bit           exp_fill_next = 1'b0;
    bit           prev_stall    = 1'b0;
    logic [W-1:0] stall_data;
    logic         stall_last;
    int           stall_left    = 0;
    bit           rand_ready    = 1'b0;

    sort8_stream #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_model(input logic [W-1:0] v [8]);
        logic [W-1:0] s [$];
        foreach (v[i]) s.push_back(v[i]);
`ifdef SORT8_STREAM_ASCENDING_EN
        s.sort();
`else
        s.rsort();
`endif
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_fill_next = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            if (exp_fill_next) begin
                check("turnaround_in_ready", in_ready, 1);
                check("turnaround_out_valid", out_valid, 0);
                exp_fill_next = 1'b0;
            end
            if (prev_stall) begin
                check("stall_out_valid", out_valid, 1);
                check("stall_out_data", out_data, stall_data);
                check("stall_out_last", out_last, stall_last);
            end
            prev_stall = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("out_data", out_data, exp_v);
                    check("out_last", out_last, (exp_q.size() == 0) ? 1 : 0);
                    if (exp_q.size() == 0) exp_fill_next = 1'b1;
                end
            end
        end
    end

    // ---------------- consumer driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && stall_left > 0) begin
                out_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // ---------------- producer driver tasks ----------------
    task automatic send_elem(input logic [W-1:0] v, input bit gap);
        if (gap) begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
            check("in_ready_gap", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        check("in_ready_fill", in_ready, 1);
        check("out_valid_fill", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit hold_in, input int stop_at);
        int budget = 300;
        while (exp_q.size() > stop_at && budget > 0) begin
            check("in_ready_drain", in_ready, 0);
            check("out_valid_drain", out_valid, 1);
            if (hold_in) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
            end
            @(posedge clk);
            #1;
            budget--;
        end
        in_valid = 1'b0;
        if (budget == 0) begin
            check("drain_timeout", exp_q.size(), stop_at);
            exp_q.delete();
        end
    endtask

    // gap_mode: 0 none, 1 alternate idle cycles, 2 random idle cycles
    task automatic fill_batch(input logic [W-1:0] v [8], input int gap_mode);
        for (int i = 0; i < 8; i++) begin
            send_elem(v[i], (gap_mode == 1) ? (i % 2 == 1) :
                            (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        push_model(v);
        check("fill_latency_out_valid", out_valid, 1);
        check("fill_latency_in_ready", in_ready, 0);
    endtask

    task automatic send_batch(input logic [W-1:0] v [8], input int gap_mode, input bit hold_in);
        fill_batch(v, gap_mode);
        wait_drain(hold_in, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        stall_left = 0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("reset_hold_out_valid", out_valid, 0);
        check("reset_hold_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_batch(output logic [W-1:0] v [8]);
        bit narrow = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            v[i] = narrow ? W'($urandom_range(0, 7)) : W'($urandom_range(0, 255));
        end
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] b_basic [8] = '{8'd3, 8'd200, 8'd17, 8'd17, 8'd0, 8'd255, 8'd90, 8'd1};
    logic [W-1:0] b_equal [8] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    logic [W-1:0] b_up    [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    logic [W-1:0] b_down  [8] = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    logic [W-1:0] b_after [8] = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    logic [W-1:0] b_stall [8] = '{8'd12, 8'd255, 8'd40, 8'd7, 8'd255, 8'd0, 8'd99, 8'd128};
    logic [W-1:0] b_rand  [8];

    initial begin
        do_reset();

        // basic sort, consumer always ready
        send_batch(b_basic, 0, 1'b0);

        // backpressure right at the start of the drain
        stall_left = 5;
        send_batch(b_stall, 0, 1'b0);

        // all-equal and monotonic inputs
        send_batch(b_equal, 0, 1'b0);
        send_batch(b_up, 0, 1'b0);
        send_batch(b_down, 0, 1'b0);

        // reset part-way through a fill, then a clean batch
        for (int i = 0; i < 5; i++) send_elem(W'($urandom_range(0, 255)), 1'b0);
        do_reset();
        send_batch(b_after, 0, 1'b0);

        // idle cycles during the fill, producer pushing during the drain
        send_batch(b_basic, 1, 1'b1);

        // reset part-way through a drain
        rand_ready = 1'b1;
        rand_batch(b_rand);
        fill_batch(b_rand, 0);
        wait_drain(1'b0, 5);
        do_reset();
        send_batch(b_after, 0, 1'b0);

        // randomized traffic with random backpressure and gaps
        for (int n = 0; n < 12; n++) begin
            rand_batch(b_rand);
            if (n % 4 == 0) stall_left = $urandom_range(1, 6);
            send_batch(b_rand, 2, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
